pac_dir_ctrl: RTL and testbench
===============================

Name: pac_dir_ctrl

Overview:
- Upstream stage of the Pacman movement block. Turns the four raw direction buttons into the 2-bit PAC_DIRECTION that the movement stage consumes.
- Synchronises and debounces each button, then holds one queued ("pre-turn") request.
- Commits the queued request only at the frame tick, and only when Pacman is grid-aligned or the request is a reversal.
- Takes the movement stage's PAC_X/PAC_Y outputs back as inputs for the alignment check.

Parameters:
- UP, 2'd0, encoding for up; shared with the movement stage
- DOWN, 2'd1, encoding for down
- LEFT, 2'd2, encoding for left
- RIGHT, 2'd3, encoding for right
- RESET_DIR, 2'd2 (LEFT), direction driven after reset
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required before a button change is accepted (≥2)
- GRID_LOG2, 4, alignment grid is 2^GRID_LOG2 pixels (16 px = 8 px tile × scale 2)
- PENDING_FRAMES, 4'd8, frame ticks a queued request survives without committing

Ports:
- CLK  in  1  pixel/system clock
- RESET_N  in  1  asynchronous, active-low reset
- BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT  in  1 each  raw asynchronous buttons, active-high
- X_VGA, Y_VGA  in  11 signed  current scan coordinates
- PAC_X, PAC_Y  in  11 signed  current Pacman position, fed back from the movement stage
- PAC_DIRECTION  out  2  committed direction, registered
- PENDING_VALID  out  1  a queued request is held
- PENDING_DIR  out  2  the queued direction; 0 when PENDING_VALID=0

Behaviour:
- Reset (async assert, sync release): PAC_DIRECTION=RESET_DIR, PENDING_VALID=0, PENDING_DIR=0. All sync flops, debounced states, debounce counters, press edges, tick edge and expiry counter are cleared to 0.
- Sync: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - A counter increments while the synchronised input differs from the debounced state and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced state.
- Press: a 1-cycle pulse on the rising edge of a debounced state; release produces nothing.
- Simultaneous presses in one cycle: only the highest-priority one is taken, priority UP > DOWN > LEFT > RIGHT.
- Frame tick: 1-cycle pulse on the rising edge of (X_VGA==0 && Y_VGA==0). A condition held for several cycles gives one tick.
- Aligned: PAC_X[GRID_LOG2-1:0]==0 and PAC_Y[GRID_LOG2-1:0]==0. Two's-complement low bits are used, so negative off-screen positions are aligned by the same rule.
- Queue (one entry):
  - A press loads PENDING_DIR with the pressed direction, sets PENDING_VALID, and clears the expiry counter.
  - A newer press overwrites an older pending request.
- Commit, evaluated on a tick using the pending value registered before this cycle:
  - pending == PAC_DIRECTION: clear pending, no change.
  - pending is the reverse of PAC_DIRECTION (UP↔DOWN, LEFT↔RIGHT): PAC_DIRECTION <= pending, clear pending, alignment not required.
  - otherwise, if aligned: PAC_DIRECTION <= pending, clear pending.
  - otherwise: keep pending and increment the expiry counter. If the counter reaches PENDING_FRAMES, clear pending.
- Press and tick in the same cycle: the tick acts on the old pending value, and the press is loaded afterwards, so the new request wins the register. It is evaluated on the next tick.
- Latency:
  - PAC_DIRECTION changes on the clock edge that samples the tick.
  - The movement stage steps on that same tick, so the new direction takes effect one frame later.
  - Press to PENDING_VALID is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- No tick: PAC_DIRECTION never changes between ticks.
- Reset mid-debounce or with a request pending: all state is lost and outputs return to reset values immediately.

Test Plan:
- Reset: hold RESET_N=0 with buttons active -> PAC_DIRECTION=2, PENDING_VALID=0, PENDING_DIR=0. Release with no presses -> values unchanged for 3 frames.
- Glitch rejection, with DEBOUNCE_CYCLES=8: BTN_UP high for 5 cycles -> PENDING_VALID stays 0. BTN_UP held for 20 cycles -> PENDING_VALID=1, PENDING_DIR=0 at 2+8+1 cycles after assertion.
- Aligned commit: direction LEFT, PAC_X=32, PAC_Y=48, press UP, then tick -> PAC_DIRECTION=0 and PENDING_VALID=0 on the tick edge.
- Unaligned hold then commit: PAC_X=35, press DOWN, tick -> pending kept, direction stays LEFT. Set PAC_X=32, tick -> PAC_DIRECTION=1.
- Reversal and expiry:
  - Direction LEFT, PAC_X=35, press RIGHT, tick -> PAC_DIRECTION=3.
  - Separately, press UP at PAC_X=35 with PENDING_FRAMES=4 -> PENDING_VALID clears on the 4th tick and direction is unchanged.
- Priority and same-cycle collision:
  - Assert UP and RIGHT debounced in the same cycle -> PENDING_DIR=0.
  - Press pulse coinciding with a tick -> old pending is evaluated, new direction is held and committed on the next tick.

Source files
------------

// File: rtl/pac_dir_ctrl.sv
// Pacman direction front end: debounced buttons feed a one-entry pre-turn
// queue that commits on the frame tick when grid-aligned or reversing.

module pac_dir_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    logic        sync1;
    logic        sync2;
    logic        state;
    logic        state_d;
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            state   <= 1'b0;
            state_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            state_d <= state;
            // Any cycle where input matches the accepted state restarts the count
            if (sync2 != state) begin
                if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
                    state <= ~state;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = state & ~state_d;
endmodule

module pac_dir_ctrl #(
    parameter logic [1:0]  UP              = 2'd0,
    parameter logic [1:0]  DOWN            = 2'd1,
    parameter logic [1:0]  LEFT            = 2'd2,
    parameter logic [1:0]  RIGHT           = 2'd3,
    parameter logic [1:0]  RESET_DIR       = 2'd2,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          GRID_LOG2       = 4,
    parameter logic [3:0]  PENDING_FRAMES  = 4'd8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               BTN_UP,
    input  logic               BTN_DOWN,
    input  logic               BTN_LEFT,
    input  logic               BTN_RIGHT,
    input  logic signed [10:0] X_VGA,
    input  logic signed [10:0] Y_VGA,
    input  logic signed [10:0] PAC_X,
    input  logic signed [10:0] PAC_Y,
    output logic [1:0]         PAC_DIRECTION,
    output logic               PENDING_VALID,
    output logic [1:0]         PENDING_DIR
);
    // Button vector ordered by priority, index 0 highest
    logic [3:0] btn;
    logic [3:0] press;
    assign btn = {BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

    pac_dir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [3:0] (
        .clk   (CLK),
        .rst_n (RESET_N),
        .btn   (btn),
        .press (press)
    );

    logic       press_any;
    logic [1:0] press_dir;

    always_comb begin
        press_any = |press;
        press_dir = RIGHT;
        if (press[0])      press_dir = UP;
        else if (press[1]) press_dir = DOWN;
        else if (press[2]) press_dir = LEFT;
    end

    logic frame_zero;
    logic zero_d;
    logic tick;
    assign frame_zero = (X_VGA == 11'sd0) && (Y_VGA == 11'sd0);
    assign tick       = frame_zero & ~zero_d;

    logic aligned;
    logic unused_hi;
    assign aligned   = (PAC_X[GRID_LOG2-1:0] == '0) && (PAC_Y[GRID_LOG2-1:0] == '0);
    assign unused_hi = ^{PAC_X[10:GRID_LOG2], PAC_Y[10:GRID_LOG2]};

    function automatic logic [1:0] reverse_of(input logic [1:0] d);
        logic [1:0] r;
        r = LEFT;
        if (d == UP)        r = DOWN;
        else if (d == DOWN) r = UP;
        else if (d == LEFT) r = RIGHT;
        return r;
    endfunction

    logic [3:0] expire_cnt;
    logic [3:0] expire_inc;
    logic       is_reverse;
    assign expire_inc = expire_cnt + 4'd1;
    assign is_reverse = (PENDING_DIR == reverse_of(PAC_DIRECTION));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PAC_DIRECTION <= RESET_DIR;
            PENDING_VALID <= 1'b0;
            PENDING_DIR   <= 2'd0;
            expire_cnt    <= '0;
            zero_d        <= 1'b0;
        end else begin
            zero_d <= frame_zero;
            if (tick && PENDING_VALID) begin
                if (PENDING_DIR == PAC_DIRECTION) begin
                    PENDING_VALID <= 1'b0;
                    PENDING_DIR   <= 2'd0;
                end else if (is_reverse || aligned) begin
                    PAC_DIRECTION <= PENDING_DIR;
                    PENDING_VALID <= 1'b0;
                    PENDING_DIR   <= 2'd0;
                end else begin
                    expire_cnt <= expire_inc;
                    if (expire_inc == PENDING_FRAMES) begin
                        PENDING_VALID <= 1'b0;
                        PENDING_DIR   <= 2'd0;
                    end
                end
            end
            // A fresh press overrides whatever the tick left in the queue
            if (press_any) begin
                PENDING_VALID <= 1'b1;
                PENDING_DIR   <= press_dir;
                expire_cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pac_dir_ctrl.sv
// Scenario bench for pac_dir_ctrl: expected {dir,valid,pdir} tuples are queued
// as stimulus is applied and popped when the DUT state is sampled.

module tb_pac_dir_ctrl;
    localparam int D = 8;

    logic               CLK = 1'b0;
    logic               RESET_N = 1'b0;
    logic [3:0]         btn = 4'b0;
    logic signed [10:0] X_VGA = 11'sd5;
    logic signed [10:0] Y_VGA = 11'sd5;
    logic signed [10:0] PAC_X = 11'sd32;
    logic signed [10:0] PAC_Y = 11'sd48;
    logic [1:0]         PAC_DIRECTION;
    logic               PENDING_VALID;
    logic [1:0]         PENDING_DIR;

    always #5 CLK = ~CLK;

    pac_dir_ctrl #(
        .DEBOUNCE_CYCLES (16'd8),
        .PENDING_FRAMES  (4'd4)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .BTN_UP        (btn[0]),
        .BTN_DOWN      (btn[1]),
        .BTN_LEFT      (btn[2]),
        .BTN_RIGHT     (btn[3]),
        .X_VGA         (X_VGA),
        .Y_VGA         (Y_VGA),
        .PAC_X         (PAC_X),
        .PAC_Y         (PAC_Y),
        .PAC_DIRECTION (PAC_DIRECTION),
        .PENDING_VALID (PENDING_VALID),
        .PENDING_DIR   (PENDING_DIR)
    );

    typedef struct {
        string      name;
        logic [4:0] exp;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [4:0] obs;
    int         checks = 0;
    int         errors = 0;

    task automatic push(input string n, input logic [1:0] d, input logic v, input logic [1:0] p);
        exp_t x;
        x.name = n;
        x.exp  = {d, v, p};
        sb.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        btn = 4'b0;
        X_VGA = 11'sd5;
        Y_VGA = 11'sd5;
        cyc(2);
        RESET_N = 1'b1;
        cyc(2);
    endtask

    // Hold a button until the request is queued, then release and let it settle
    task automatic press(input int i);
        btn[i] = 1'b1;
        cyc(D + 3);
        btn[i] = 1'b0;
        cyc(D + 4);
    endtask

    task automatic tick();
        X_VGA = 11'sd0;
        Y_VGA = 11'sd0;
        @(negedge CLK);
        X_VGA = 11'sd5;
        Y_VGA = 11'sd5;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        btn = 4'hF;
        RESET_N = 1'b0;
        cyc(3);
        push("reset_hold", 2'd2, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        btn = 4'b0;
        cyc(2);
        RESET_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            push("reset_idle_frame", 2'd2, 1'b0, 2'd0);
            e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL %s[%0d] got %b want %b", e.name, k, obs, e.exp); end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        btn[0] = 1'b1;
        cyc(5);
        btn[0] = 1'b0;
        cyc(20);
        push("glitch_reject", 2'd2, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        btn[0] = 1'b1;
        cyc(D + 2);
        push("debounce_one_early", 2'd2, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        cyc(1);
        push("debounce_latency", 2'd2, 1'b1, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        cyc(9);
        btn[0] = 1'b0;
        cyc(D + 4);
    endtask

    task automatic test_aligned();
        apply_reset();
        PAC_X = 11'sd32;
        PAC_Y = 11'sd48;
        press(0);
        push("aligned_queued", 2'd2, 1'b1, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        tick();
        push("aligned_commit", 2'd0, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
    endtask

    task automatic test_unaligned();
        apply_reset();
        PAC_X = 11'sd35;
        PAC_Y = 11'sd48;
        press(1);
        tick();
        push("unaligned_hold", 2'd2, 1'b1, 2'd1);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        PAC_X = 11'sd32;
        tick();
        push("realigned_commit", 2'd1, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
    endtask

    task automatic test_reversal();
        apply_reset();
        PAC_X = 11'sd35;
        press(3);
        tick();
        push("reversal_commit", 2'd3, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
    endtask

    task automatic test_same_dir();
        apply_reset();
        PAC_X = 11'sd35;
        press(2);
        tick();
        push("same_dir_drop", 2'd2, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
    endtask

    task automatic test_expiry();
        apply_reset();
        PAC_X = 11'sd35;
        press(0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            push("expiry_hold", 2'd2, 1'b1, 2'd0);
            e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
            if (obs !== e.exp) begin errors++; $display("FAIL %s[%0d] got %b want %b", e.name, k, obs, e.exp); end
        end
        tick();
        push("expiry_clear", 2'd2, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
    endtask

    task automatic test_priority();
        apply_reset();
        btn = 4'b1001;
        cyc(D + 3);
        push("priority_up_over_right", 2'd2, 1'b1, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        btn = 4'b0;
        cyc(D + 4);
    endtask

    task automatic test_collision();
        apply_reset();
        PAC_X = 11'sd35;
        press(3);
        // UP press pulse lands on the same edge as the tick
        btn[0] = 1'b1;
        cyc(D + 2);
        X_VGA = 11'sd0;
        Y_VGA = 11'sd0;
        cyc(1);
        X_VGA = 11'sd5;
        Y_VGA = 11'sd5;
        cyc(1);
        push("collision_old_commit", 2'd3, 1'b1, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        btn[0] = 1'b0;
        cyc(D + 4);
        PAC_X = 11'sd32;
        tick();
        push("collision_new_commit", 2'd0, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        PAC_X = 11'sd35;
        press(0);
        btn[2] = 1'b1;
        cyc(4);
        #2 RESET_N = 1'b0;
        #1;
        push("async_reset", 2'd2, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
        @(negedge CLK);
        btn = 4'b0;
        cyc(2);
        RESET_N = 1'b1;
        cyc(D + 6);
        push("post_reset_quiet", 2'd2, 1'b0, 2'd0);
        e = sb.pop_front(); obs = {PAC_DIRECTION, PENDING_VALID, PENDING_DIR}; checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %b want %b", e.name, obs, e.exp); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_aligned();
        test_unaligned();
        test_reversal();
        test_same_dir();
        test_expiry();
        test_priority();
        test_collision();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
